// File: rtl/filter_ctrl_axil_regs_if.sv
// AXI4-Lite control-port bundle between the system master and filter_ctrl_axil_regs.
interface filter_ctrl_axil_regs_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/filter_ctrl_axil_regs.sv
// AXI4-Lite slave exposing four 32-bit byte-writable control registers to the filter datapath.
module filter_ctrl_axil_regs #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_areset,
    filter_ctrl_axil_regs_if.slave        s_axi,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg2_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg3_o,
    output logic [3:0]                    reg_wr_pulse_o
);
    localparam int unsigned NUM_REGS = 4;
    localparam int unsigned IDX_W    = 2;
    localparam int unsigned STRB_W   = C_S_AXI_DATA_WIDTH / 8;

    typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ACCEPT, R_DATA} r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;

    logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [C_S_AXI_DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [NUM_REGS-1:0]           pulse_q, pulse_d;
    logic awready_q, awready_d;
    logic bvalid_q, bvalid_d;
    logic arready_q, arready_d;
    logic rvalid_q, rvalid_d;

    logic [IDX_W-1:0] widx_c;
    logic [IDX_W-1:0] ridx_c;
    logic             unused_bits;

    assign widx_c      = s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1 -: IDX_W];
    assign ridx_c      = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1 -: IDX_W];
    assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    // Write FSM: accept only a joint AW+W, merge strobed bytes, hold B until bready.
    always_comb begin
        w_state_d = w_state_q;
        regs_d    = regs_q;
        pulse_d   = '0;
        unique case (w_state_q)
            W_IDLE: begin
                if (s_axi.awvalid && s_axi.wvalid) begin
                    w_state_d = W_ACCEPT;
                end
            end
            W_ACCEPT: begin
                w_state_d       = W_RESP;
                pulse_d[widx_c] = 1'b1;
                for (int k = 0; k < STRB_W; k++) begin
                    if (s_axi.wstrb[k]) begin
                        regs_d[widx_c][8*k +: 8] = s_axi.wdata[8*k +: 8];
                    end
                end
            end
            W_RESP: begin
                if (s_axi.bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_ACCEPT);
        bvalid_d  = (w_state_d == W_RESP);
    end

    // Read FSM: sample the addressed register on entry to R_DATA, hold it until rready.
    always_comb begin
        r_state_d = r_state_q;
        rdata_d   = rdata_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (s_axi.arvalid) begin
                    r_state_d = R_ACCEPT;
                end
            end
            R_ACCEPT: begin
                r_state_d = R_DATA;
                rdata_d   = regs_q[ridx_c];
            end
            R_DATA: begin
                if (s_axi.rready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_ACCEPT);
        rvalid_d  = (r_state_d == R_DATA);
    end

    // State, storage and registered handshake outputs with synchronous reset.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            rdata_q   <= '0;
            pulse_q   <= '0;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            rdata_q   <= rdata_d;
            pulse_q   <= pulse_d;
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign s_axi.awready  = awready_q;
    assign s_axi.wready   = awready_q;
    assign s_axi.bvalid   = bvalid_q;
    assign s_axi.bresp    = 2'b00;
    assign s_axi.arready  = arready_q;
    assign s_axi.rvalid   = rvalid_q;
    assign s_axi.rdata    = rdata_q;
    assign s_axi.rresp    = 2'b00;
    assign reg0_o         = regs_q[0];
    assign reg1_o         = regs_q[1];
    assign reg2_o         = regs_q[2];
    assign reg3_o         = regs_q[3];
    assign reg_wr_pulse_o = pulse_q;
endmodule

// File: tb/tb_filter_ctrl_axil_regs.sv
// Self-checking bench for filter_ctrl_axil_regs against a simple register-array model.
module tb_filter_ctrl_axil_regs;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] reg0, reg1, reg2, reg3;
    logic [3:0]  pulse;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] mdl [4];

    filter_ctrl_axil_regs_if bus ();

    filter_ctrl_axil_regs dut (
        .s_axi_aclk     (clk),
        .s_axi_areset   (rst),
        .s_axi          (bus),
        .reg0_o         (reg0),
        .reg1_o         (reg1),
        .reg2_o         (reg2),
        .reg3_o         (reg3),
        .reg_wr_pulse_o (pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~m) | (n & m);
    endfunction

    function automatic logic [31:0] reg_obs(input logic [1:0] i);
        case (i)
            2'd0:    return reg0;
            2'd1:    return reg1;
            2'd2:    return reg2;
            default: return reg3;
        endcase
    endfunction

    task automatic idle_bus;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        bus.bready  = 1'b1; bus.rready = 1'b1;
        bus.awaddr  = '0; bus.araddr = '0; bus.wdata = '0; bus.wstrb = '0;
        bus.awprot  = 3'($urandom_range(0, 7)); bus.arprot = 3'($urandom_range(0, 7));
    endtask

    // Bus driver: one full write; returns what was seen on the B beat.
    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [3:0] p, output logic [1:0] resp,
                             output logic [31:0] regv, output int lat, output bit to);
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
        to = 1'b0; lat = 0;
        do begin tick(); lat++; end while (!bus.awready && lat < 50);
        if (!bus.awready) to = 1'b1;
        tick(); lat++;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        while (!bus.bvalid && lat < 100) begin tick(); lat++; end
        if (!bus.bvalid) to = 1'b1;
        p = pulse; resp = bus.bresp; regv = reg_obs(a[3:2]);
        tick();
    endtask

    // Bus driver: one full read; returns the R beat.
    task automatic axi_read(input logic [3:0] a, output logic [31:0] rd, output logic [1:0] rr,
                            output int lat, output bit to);
        bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
        to = 1'b0; lat = 0;
        do begin tick(); lat++; end while (!bus.arready && lat < 50);
        if (!bus.arready) to = 1'b1;
        tick(); lat++;
        bus.arvalid = 1'b0;
        while (!bus.rvalid && lat < 100) begin tick(); lat++; end
        if (!bus.rvalid) to = 1'b1;
        rd = bus.rdata; rr = bus.rresp;
        tick();
    endtask

    task automatic test_reset;
        logic [31:0] rd; logic [1:0] rr; int lat; bit to;
        idle_bus();
        rst = 1'b1;
        tick(); tick();
        for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
        total++; if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid} !== 5'b0) begin bad++; $display("FAIL reset_hs: got %b exp 00000", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid}); end
        total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h exp 0", bus.rdata); end
        total++; if (pulse !== 4'h0) begin bad++; $display("FAIL reset_pulse: got %b exp 0000", pulse); end
        total++; if ({reg0, reg1, reg2, reg3} !== 128'h0) begin bad++; $display("FAIL reset_regs: got %h %h %h %h exp 0", reg0, reg1, reg2, reg3); end
        total++; if ({bus.bresp, bus.rresp} !== 4'b0) begin bad++; $display("FAIL reset_resp: got %b exp 0000", {bus.bresp, bus.rresp}); end
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), rd, rr, lat, to);
            total++; if (to !== 1'b0) begin bad++; $display("FAIL reset_read_timeout[%0d]: got %b exp 0", i, to); end
            total++; if (rd !== mdl[i]) begin bad++; $display("FAIL reset_read[%0d]: got %h exp %h", i, rd, mdl[i]); end
            total++; if (rr !== 2'b00) begin bad++; $display("FAIL reset_rresp[%0d]: got %b exp 00", i, rr); end
        end
    endtask

    task automatic test_write_read;
        logic [3:0] p; logic [1:0] resp; logic [31:0] regv, rd; logic [1:0] rr; int lat; bit to;
        for (int i = 0; i < 4; i++) begin
            axi_write(4'(i * 4), 32'(i + 1), 4'hF, p, resp, regv, lat, to);
            mdl[i] = merge(mdl[i], 32'(i + 1), 4'hF);
            total++; if (to !== 1'b0) begin bad++; $display("FAIL wr_timeout[%0d]: got %b exp 0", i, to); end
            total++; if (resp !== 2'b00) begin bad++; $display("FAIL wr_bresp[%0d]: got %b exp 00", i, resp); end
            total++; if (p !== 4'(1 << i)) begin bad++; $display("FAIL wr_pulse[%0d]: got %b exp %b", i, p, 4'(1 << i)); end
            total++; if (regv !== mdl[i]) begin bad++; $display("FAIL wr_reg[%0d]: got %h exp %h", i, regv, mdl[i]); end
            total++; if (lat !== 2) begin bad++; $display("FAIL wr_latency[%0d]: got %0d exp 2", i, lat); end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), rd, rr, lat, to);
            total++; if (rd !== 32'(i + 1)) begin bad++; $display("FAIL rd_back[%0d]: got %h exp %h", i, rd, 32'(i + 1)); end
            total++; if (lat !== 2) begin bad++; $display("FAIL rd_latency[%0d]: got %0d exp 2", i, lat); end
        end
    endtask

    task automatic test_strobe;
        logic [3:0] p; logic [1:0] resp; logic [31:0] regv; int lat; bit to;
        axi_write(4'h4, 32'hAABBCCDD, 4'hF, p, resp, regv, lat, to);
        mdl[1] = merge(mdl[1], 32'hAABBCCDD, 4'hF);
        axi_write(4'h4, 32'h11223344, 4'b0101, p, resp, regv, lat, to);
        mdl[1] = merge(mdl[1], 32'h11223344, 4'b0101);
        total++; if (reg1 !== 32'hAA22CC44) begin bad++; $display("FAIL strobe_reg1: got %h exp aa22cc44", reg1); end
        total++; if (p !== 4'b0010) begin bad++; $display("FAIL strobe_pulse: got %b exp 0010", p); end
    endtask

    task automatic test_split_aw_w;
        logic [3:0] p; logic [1:0] resp; logic [31:0] regv; int lat; bit to;
        logic [31:0] a_val = 32'h5A5A0001;
        logic [31:0] b_val = 32'h5A5A0002;
        bus.bready = 1'b0;
        bus.awaddr = 4'hC; bus.wdata = a_val; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            total++; if ({bus.awready, bus.wready} !== 2'b00) begin bad++; $display("FAIL split_ready_c%0d: got %b exp 00", c, {bus.awready, bus.wready}); end
            total++; if (reg3 !== mdl[3]) begin bad++; $display("FAIL split_early_c%0d: got %h exp %h", c, reg3, mdl[3]); end
        end
        bus.wvalid = 1'b1;
        tick();
        total++; if ({bus.awready, bus.wready} !== 2'b11) begin bad++; $display("FAIL split_accept: got %b exp 11", {bus.awready, bus.wready}); end
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        mdl[3] = a_val;
        total++; if (bus.bvalid !== 1'b1) begin bad++; $display("FAIL split_bvalid: got %b exp 1", bus.bvalid); end
        total++; if (reg3 !== mdl[3]) begin bad++; $display("FAIL split_reg: got %h exp %h", reg3, mdl[3]); end
        total++; if (pulse !== 4'b1000) begin bad++; $display("FAIL split_pulse: got %b exp 1000", pulse); end
        bus.wdata = b_val; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            total++; if (bus.bvalid !== 1'b1) begin bad++; $display("FAIL hold_bvalid_c%0d: got %b exp 1", c, bus.bvalid); end
            total++; if ({bus.awready, bus.wready} !== 2'b00) begin bad++; $display("FAIL hold_ready_c%0d: got %b exp 00", c, {bus.awready, bus.wready}); end
            total++; if (reg3 !== mdl[3]) begin bad++; $display("FAIL hold_reg_c%0d: got %h exp %h", c, reg3, mdl[3]); end
        end
        axi_write(4'hC, b_val, 4'hF, p, resp, regv, lat, to);
        mdl[3] = b_val;
        total++; if (to !== 1'b0) begin bad++; $display("FAIL split_second_timeout: got %b exp 0", to); end
        total++; if (regv !== mdl[3]) begin bad++; $display("FAIL split_second_reg: got %h exp %h", regv, mdl[3]); end
    endtask

    task automatic test_collision;
        logic [3:0] p; logic [1:0] resp; logic [31:0] regv, rd, old; logic [1:0] rr; int lat; bit to;
        logic [31:0] seed = $urandom;
        axi_write(4'h8, seed, 4'hF, p, resp, regv, lat, to);
        mdl[2] = seed;
        old = mdl[2];
        bus.araddr = 4'h8; bus.awaddr = 4'h8; bus.wdata = 32'h0000DEAD; bus.wstrb = 4'hF;
        bus.arvalid = 1'b1; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        tick();
        total++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin bad++; $display("FAIL coll_accept: got %b exp 111", {bus.awready, bus.wready, bus.arready}); end
        tick();
        bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        mdl[2] = merge(mdl[2], 32'h0000DEAD, 4'hF);
        total++; if ({bus.rvalid, bus.bvalid} !== 2'b11) begin bad++; $display("FAIL coll_valid: got %b exp 11", {bus.rvalid, bus.bvalid}); end
        total++; if (bus.rdata !== old) begin bad++; $display("FAIL coll_rdata_old: got %h exp %h", bus.rdata, old); end
        total++; if (reg2 !== mdl[2]) begin bad++; $display("FAIL coll_reg2: got %h exp %h", reg2, mdl[2]); end
        tick();
        axi_read(4'h8, rd, rr, lat, to);
        total++; if (rd !== 32'h0000DEAD) begin bad++; $display("FAIL coll_reread: got %h exp 0000dead", rd); end
    endtask

    task automatic test_random;
        logic [3:0] p; logic [1:0] resp; logic [31:0] regv, rd, d; logic [1:0] rr; int lat; bit to;
        logic [3:0] a, s, ra;
        for (int n = 0; n < 24; n++) begin
            a = 4'($urandom_range(0, 15)); d = $urandom; s = 4'($urandom_range(0, 15));
            axi_write(a, d, s, p, resp, regv, lat, to);
            mdl[a[3:2]] = merge(mdl[a[3:2]], d, s);
            total++; if (regv !== mdl[a[3:2]]) begin bad++; $display("FAIL rnd_reg[%0d]: addr %h strb %b got %h exp %h", n, a, s, regv, mdl[a[3:2]]); end
            total++; if (p !== 4'(1 << a[3:2])) begin bad++; $display("FAIL rnd_pulse[%0d]: got %b exp %b", n, p, 4'(1 << a[3:2])); end
            ra = 4'($urandom_range(0, 15));
            axi_read(ra, rd, rr, lat, to);
            total++; if (rd !== mdl[ra[3:2]]) begin bad++; $display("FAIL rnd_read[%0d]: addr %h got %h exp %h", n, ra, rd, mdl[ra[3:2]]); end
        end
        total++; if ({reg0, reg1, reg2, reg3} !== {mdl[0], mdl[1], mdl[2], mdl[3]}) begin bad++; $display("FAIL rnd_regs_final: got %h %h %h %h exp %h %h %h %h", reg0, reg1, reg2, reg3, mdl[0], mdl[1], mdl[2], mdl[3]); end
    endtask

    task automatic test_back_to_back;
        logic [3:0] p; logic [1:0] resp; logic [31:0] regv, rd, d; logic [1:0] rr; int lat; bit to;
        int c0;
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            axi_write(4'(i * 4), d, 4'hF, p, resp, regv, lat, to);
            mdl[i] = d;
        end
        total++; if (cyc - c0 !== 12) begin bad++; $display("FAIL b2b_write_cycles: got %0d exp 12", cyc - c0); end
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), rd, rr, lat, to);
            total++; if (rd !== mdl[i]) begin bad++; $display("FAIL b2b_read[%0d]: got %h exp %h", i, rd, mdl[i]); end
        end
        total++; if (cyc - c0 !== 12) begin bad++; $display("FAIL b2b_read_cycles: got %0d exp 12", cyc - c0); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic [1:0] rr; int lat; bit to;
        bus.rready = 1'b0; bus.araddr = 4'h0; bus.arvalid = 1'b1;
        tick(); tick();
        bus.arvalid = 1'b0;
        total++; if (bus.rvalid !== 1'b1) begin bad++; $display("FAIL mid_rvalid: got %b exp 1", bus.rvalid); end
        total++; if (bus.rdata !== mdl[0]) begin bad++; $display("FAIL mid_rdata: got %h exp %h", bus.rdata, mdl[0]); end
        tick(); tick();
        total++; if ({bus.rvalid, bus.rdata} !== {1'b1, mdl[0]}) begin bad++; $display("FAIL mid_hold: got %b/%h exp 1/%h", bus.rvalid, bus.rdata, mdl[0]); end
        rst = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
        total++; if (bus.rvalid !== 1'b0) begin bad++; $display("FAIL mid_rvalid_drop: got %b exp 0", bus.rvalid); end
        total++; if ({reg0, reg1, reg2, reg3} !== 128'h0) begin bad++; $display("FAIL mid_regs_clear: got %h %h %h %h exp 0", reg0, reg1, reg2, reg3); end
        rst = 1'b0;
        bus.rready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), rd, rr, lat, to);
            total++; if (rd !== mdl[i]) begin bad++; $display("FAIL mid_read[%0d]: got %h exp %h", i, rd, mdl[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_strobe();
        test_split_aw_w();
        test_collision();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
